// File: rtl/imem_dmem_arbiter.sv
// Arbiter that shares one single-ported memory between instruction fetch and load/store.
// Data accesses win by default. A streak counter lets a pending fetch through after STARVE_LIMIT data grants.
module imem_dmem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int AW           = 32,
    parameter int DW           = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [DW-1:0]   if_rdata,
    input  logic            dm_req,
    input  logic            dm_we,
    input  logic [DW/8-1:0] dm_be,
    input  logic [AW-1:0]   dm_addr,
    input  logic [DW-1:0]   dm_wdata,
    output logic            dm_gnt,
    output logic            dm_rvalid,
    output logic [DW-1:0]   dm_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [DW-1:0]   mem_rdata,
    output logic            busy
);

    localparam int BW = DW / 8;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic            owner_reg;          // 1 = data path owns the transaction
    logic [SW-1:0]   streak_reg;
    logic            we_reg;
    logic [BW-1:0]   be_reg;
    logic [AW-1:0]   addr_reg;
    logic [DW-1:0]   wdata_reg;

    logic            arb_en;
    logic            starved;
    logic            data_win;
    logic            fetch_win;

    // Grants are combinational, so keep them quiet while reset is held.
    assign arb_en    = (state_reg == IDLE) && rst_n;
    assign starved   = (streak_reg == SW'(STARVE_LIMIT));
    assign data_win  = arb_en && dm_req && !(if_req && starved);
    assign fetch_win = arb_en && if_req && !data_win;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (data_win || fetch_win) state_next = ISSUE;
            ISSUE:   if (mem_gnt)               state_next = WAIT;
            WAIT:    if (mem_rvalid)            state_next = IDLE;
            default:                            state_next = IDLE;
        endcase
    end

    always_comb begin
        if_gnt    = fetch_win;
        dm_gnt    = data_win;
        mem_req   = (state_reg == ISSUE);
        busy      = (state_reg != IDLE);
        if_rvalid = (state_reg == WAIT) && mem_rvalid && !owner_reg;
        dm_rvalid = (state_reg == WAIT) && mem_rvalid &&  owner_reg;
    end

    // Request fields are captured at grant so the memory port never sees requester changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_reg  <= 1'b0;
            streak_reg <= '0;
            we_reg     <= 1'b0;
            be_reg     <= '0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
        end else if (data_win) begin
            owner_reg <= 1'b1;
            we_reg    <= dm_we;
            be_reg    <= dm_be;
            addr_reg  <= dm_addr;
            wdata_reg <= dm_wdata;
            if (!if_req) begin
                streak_reg <= '0;
            end else if (!starved) begin
                streak_reg <= streak_reg + SW'(1);
            end
        end else if (fetch_win) begin
            owner_reg  <= 1'b0;
            we_reg     <= 1'b0;
            be_reg     <= '1;
            addr_reg   <= if_addr;
            wdata_reg  <= '0;
            streak_reg <= '0;
        end
    end

    assign mem_we    = we_reg;
    assign mem_be    = be_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign if_rdata  = mem_rdata;
    assign dm_rdata  = mem_rdata;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter: the memory side is driven by hand, one step per cycle.
// Inputs change on the falling edge and outputs are sampled 1ns later.
module tb_imem_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    imem_dmem_arbiter #(.STARVE_LIMIT(4), .AW(32), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_be = '0; dm_addr = '0; dm_wdata = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

        // Reset state
        @(negedge clk); #1;
        chk("rst_busy", busy, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_gnts", {if_gnt, dm_gnt, if_rvalid, dm_rvalid}, 0);

        // Single fetch
        @(negedge clk); rst_n = 1'b1; if_req = 1'b1; if_addr = 32'h100; #1;
        chk("f_if_gnt", if_gnt, 1);
        chk("f_dm_gnt", dm_gnt, 0);
        chk("f_busy_T", busy, 0);
        @(negedge clk); if_req = 1'b0; mem_gnt = 1'b1; #1;
        chk("f_mem_req", mem_req, 1);
        chk("f_mem_addr", mem_addr, 32'h100);
        chk("f_mem_we", mem_we, 0);
        chk("f_mem_be", mem_be, 4'hF);
        @(negedge clk); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h00500093; #1;
        chk("f_if_rvalid", if_rvalid, 1);
        chk("f_if_rdata", if_rdata, 32'h00500093);
        chk("f_dm_rvalid", dm_rvalid, 0);
        chk("f_wait_mem_req", mem_req, 0);
        @(negedge clk); mem_rvalid = 1'b0; #1;
        chk("f_busy_T3", busy, 0);

        // Store with byte enables
        @(negedge clk); dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0011;
        dm_addr = 32'h2004; dm_wdata = 32'hDEADBEEF; #1;
        chk("s_dm_gnt", dm_gnt, 1);
        chk("s_if_gnt", if_gnt, 0);
        @(negedge clk); dm_req = 1'b0; dm_we = 1'b0; dm_wdata = '0; mem_gnt = 1'b1; #1;
        chk("s_mem_we", mem_we, 1);
        chk("s_mem_be", mem_be, 4'b0011);
        chk("s_mem_addr", mem_addr, 32'h2004);
        chk("s_mem_wdata", mem_wdata, 32'hDEADBEEF);
        @(negedge clk); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = '0; #1;
        chk("s_dm_rvalid", dm_rvalid, 1);
        chk("s_if_rvalid", if_rvalid, 0);
        @(negedge clk); mem_rvalid = 1'b0; #1;
        chk("s_busy_done", busy, 0);

        // Simultaneous requests held from reset
        @(negedge clk); rst_n = 1'b0; if_req = 1'b1; if_addr = 32'h300;
        dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h4000; #1;
        chk("sim_rst_gnts", {if_gnt, dm_gnt}, 0);
        @(negedge clk); rst_n = 1'b1; #1;
        chk("sim_dm_gnt", dm_gnt, 1);
        chk("sim_if_gnt", if_gnt, 0);
        @(negedge clk); dm_req = 1'b0; mem_gnt = 1'b1; #1;
        chk("sim_mem_addr_d", mem_addr, 32'h4000);
        chk("sim_no_gnt_issue", if_gnt, 0);
        @(negedge clk); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h11112222; #1;
        chk("sim_dm_rdata", dm_rdata, 32'h11112222);
        chk("sim_rv_route", {if_rvalid, dm_rvalid}, 2'b01);
        @(negedge clk); mem_rvalid = 1'b0; #1;
        chk("sim_if_gnt2", if_gnt, 1);
        @(negedge clk); mem_gnt = 1'b1; #1;
        chk("sim_mem_addr_f", mem_addr, 32'h300);
        @(negedge clk); mem_gnt = 1'b0; mem_rvalid = 1'b1; #1;
        chk("sim_if_rvalid", if_rvalid, 1);

        // Starvation guard: both held, expect D,D,D,D,F,D
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); mem_rvalid = 1'b0; dm_req = 1'b1; if_req = 1'b1; #1;
            chk($sformatf("starve_dgnt%0d", i), dm_gnt, (i != 4));
            chk($sformatf("starve_fgnt%0d", i), if_gnt, (i == 4));
            @(negedge clk); mem_gnt = 1'b1; #1;
            chk($sformatf("starve_addr%0d", i), mem_addr, (i == 4) ? 32'h300 : 32'h4000);
            @(negedge clk); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = i; #1;
            chk($sformatf("starve_rv%0d", i), {if_rvalid, dm_rvalid}, (i == 4) ? 2'b10 : 2'b01);
        end
        @(negedge clk); mem_rvalid = 1'b0; dm_req = 1'b0; if_req = 1'b0;
        @(negedge clk); #1;
        chk("starve_idle", busy, 0);

        // Memory wait states on a load
        dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'b1100; dm_addr = 32'h3000; #1;
        chk("ws_dm_gnt", dm_gnt, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); dm_addr = 32'h5555; if_req = 1'b1; mem_gnt = (i == 3); #1;
            chk($sformatf("ws_mem_req%0d", i), mem_req, 1);
            chk($sformatf("ws_mem_addr%0d", i), mem_addr, 32'h3000);
            chk($sformatf("ws_mem_be%0d", i), mem_be, 4'b1100);
            chk($sformatf("ws_no_gnt%0d", i), {if_gnt, dm_gnt}, 0);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); dm_req = 1'b0; if_req = 1'b0; mem_gnt = 1'b0;
            mem_rvalid = (i == 2); mem_rdata = 32'hCAFEF00D; #1;
            chk($sformatf("ws_wait_req%0d", i), mem_req, 0);
            chk($sformatf("ws_rv%0d", i), {if_rvalid, dm_rvalid}, (i == 2) ? 2'b01 : 2'b00);
        end
        chk("ws_dm_rdata", dm_rdata, 32'hCAFEF00D);
        @(negedge clk); mem_rvalid = 1'b0; #1;
        chk("ws_idle", busy, 0);

        // Reset while in WAIT
        if_req = 1'b1; if_addr = 32'h700; #1;
        chk("rw_if_gnt", if_gnt, 1);
        @(negedge clk); if_req = 1'b0; mem_gnt = 1'b1;
        @(negedge clk); mem_gnt = 1'b0; #1;
        chk("rw_in_wait", busy, 1);
        rst_n = 1'b0; mem_rvalid = 1'b1; #1;
        chk("rw_busy", busy, 0);
        chk("rw_mem_addr", mem_addr, 0);
        chk("rw_rvalid", {if_rvalid, dm_rvalid}, 0);
        @(negedge clk); rst_n = 1'b1; mem_rvalid = 1'b0;
        if_req = 1'b1; if_addr = 32'h200; #1;
        chk("rw_new_gnt", if_gnt, 1);
        @(negedge clk); if_req = 1'b0; mem_gnt = 1'b1; #1;
        chk("rw_new_addr", mem_addr, 32'h200);
        @(negedge clk); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h00100073; #1;
        chk("rw_new_rvalid", if_rvalid, 1);
        chk("rw_new_rdata", if_rdata, 32'h00100073);

        // Stray rvalid while idle
        @(negedge clk); mem_rvalid = 1'b1; #1;
        chk("stray_rv", {if_rvalid, dm_rvalid}, 0);
        chk("stray_busy", busy, 0);
        @(negedge clk); mem_rvalid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one unified single-ported memory between the instruction-fetch path and the load/store path of the RV32I core.
- Accepts one request at a time and replays it on the memory port until granted.
- Routes the read data or write acknowledge back to the owning requester.
- Gives data accesses priority, with a starvation guard for fetch; sits between the core datapath and the memory model.

Parameters:
STARVE_LIMIT, 4, consecutive data grants allowed while fetch is pending before fetch wins (>=1)
AW, 32, address width
DW, 32, data width

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request; held with if_addr until if_gnt
if_addr  in  AW  fetch address
if_gnt  out  1  one-cycle pulse: fetch request accepted
if_rvalid  out  1  one-cycle pulse: if_rdata valid
if_rdata  out  DW  fetch data
dm_req  in  1  data request; held with fields until dm_gnt
dm_we  in  1  1=store, 0=load
dm_be  in  DW/8  byte enables
dm_addr  in  AW  data address
dm_wdata  in  DW  store data
dm_gnt  out  1  one-cycle pulse: data request accepted
dm_rvalid  out  1  one-cycle pulse: load data valid or store acknowledged
dm_rdata  out  DW  load data
mem_req  out  1  memory request
mem_we  out  1  memory write enable
mem_be  out  DW/8  memory byte enables
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_gnt  in  1  memory accepted request this cycle
mem_rvalid  in  1  memory response (read data or write ack)
mem_rdata  in  DW  memory read data
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, owner=FETCH, streak=0, latched we/be/addr/wdata=0. All out ports 0.
- Reset mid-transaction abandons it silently; the memory is reset together with this block.
- State IDLE:
  - Arbitrate on registered-free inputs.
  - Winner rule: dm_req alone -> data; if_req alone -> fetch. Both -> data, unless streak==STARVE_LIMIT, then fetch.
  - On a winner: pulse its *_gnt (combinational, same cycle); latch owner and fields (fetch: we=0, be=all ones, wdata=0); next state ISSUE.
  - No request -> stay in IDLE.
- Streak update at each IDLE grant:
  - Data granted while if_req=1 -> streak+1, saturating at STARVE_LIMIT.
  - Fetch granted, or data granted with if_req=0 -> streak=0.
- State ISSUE:
  - mem_req=1; mem_* driven from latched registers only, stable until mem_gnt.
  - mem_gnt=1 -> WAIT; else stay.
- State WAIT:
  - mem_req=0.
  - On mem_rvalid: owner's *_rvalid=1 that cycle; next IDLE.
  - mem_rvalid in ISSUE or IDLE is ignored (memory guarantees rvalid no earlier than the cycle after mem_gnt).
- Data return: if_rdata and dm_rdata are driven by mem_rdata combinationally. Only the owner's rvalid asserts; the non-owner rvalid stays 0.
- Latency: accept cycle T (gnt). With mem_gnt at T+1 and mem_rvalid at T+2, *_rvalid is at T+2 and next accept is at T+3.
  - Minimum 3 cycles per transaction; memory wait states extend ISSUE/WAIT cycle-for-cycle.
- Requesters ignore their inputs being sampled outside IDLE. A request raised during ISSUE/WAIT waits, held, until IDLE.
- busy is combinational from state.

Test Plan:
- Single fetch: if_req=1, if_addr=0x100; memory grants at once and returns 0x00500093 one cycle later -> if_gnt at T, mem_req/mem_addr=0x100 at T+1, if_rvalid=1 with if_rdata=0x00500093 at T+2, busy low at T+3.
- Store with byte enables: dm_req, dm_we=1, dm_be=4'b0011, dm_addr=0x2004, dm_wdata=0xDEADBEEF -> mem_we=1, mem_be=0011, fields match at ISSUE; dm_rvalid pulse on ack; if_rvalid stays 0.
- Simultaneous requests: if_req and dm_req both high from reset -> data granted first; fetch granted at the next IDLE once dm_req drops.
- Starvation guard (STARVE_LIMIT=4): if_req held high, dm_req held high continuously -> grant order D,D,D,D,F,D…; streak returns to 0 after F.
- Memory wait states: mem_gnt delayed 3 cycles, mem_rvalid delayed 2 more -> mem_req and fields stable for 4 ISSUE cycles, rvalid routed correctly, no extra gnt pulses.
- Reset mid-WAIT: assert rst_n=0 in WAIT -> all outputs 0 immediately; after release a new fetch completes normally; stray mem_rvalid while IDLE produces no rvalid.
